axon_output_drain: RTL
======================

# axon_output_drain

Downstream stage of the AXON output-stationary PE array. It captures the array's bottom-row output bus, one `Dimension`-lane row per valid beat, into a local row buffer. Once a full tile of `Dimension` rows is held, it replays the rows in capture order over a valid/ready stream to the write-back path, so the array never stalls on memory back-pressure during ejection.

## Interface
- `DW`, default 16: signed word width per lane; matches the array.
- `Dimension`, default 16: lanes per row and rows per tile.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that arms capture of a new tile.
- `capture_valid`  in  1  the array output bus carries a valid row this cycle; driven by array control, in step with `output_eject_ctrl`.
- `array_out`  in  `DW*Dimension`  array bottom-row outputs; lane k is bits `[DW*(k+1)-1 : DW*k]`.
- `m_data`  out  `DW*Dimension`  row presented downstream; lane layout identical to `array_out`.
- `m_valid`  out  1  `m_data` holds a valid row.
- `m_ready`  in  1  downstream accepts the row.
- `m_last`  out  1  high with `m_valid` on row `Dimension-1`.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse after the last row handshake.
- `err`  out  1  sticky flag for a dropped capture beat.

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE: `start` moves the block to CAPTURE, clears the write row counter, clears `err`.
- CAPTURE: each `capture_valid` cycle writes `array_out` into buffer row `wr_cnt`, then increments `wr_cnt`.
    - Gaps in `capture_valid` are allowed; the block waits.
    - The beat with `wr_cnt == Dimension-1` moves the block to DRAIN.
- DRAIN: rows go out in capture order, 0 first.
    - A handshake is `m_valid & m_ready`. Each handshake advances `rd_cnt`.
    - The handshake with `rd_cnt == Dimension-1` pulses `done` and returns the block to IDLE.
- `start` outside IDLE is ignored and does not restart the tile.
- `capture_valid` outside CAPTURE drops the data and sets `err`; state is unchanged.
- Data is stored and forwarded bit-exact: no arithmetic, truncation or sign change.
- Counter width is `max(1, $clog2(Dimension))`. Counters never wrap within a tile.
- `Dimension = 1`: the single capture beat goes straight to DRAIN. Row 0 is forwarded from `array_out` into the `m_data` register.

## Timing
- Reset values: state IDLE, `m_data` 0, `m_valid` 0, `m_last` 0, `busy` 0, `done` 0, `err` 0, both counters 0.
- Buffer storage is not reset.
- `m_data`, `m_valid`, `m_last` and `done` are registered outputs.
- `busy` rises the cycle after `start` is accepted.
- `m_valid` rises the cycle after the final capture beat, with `m_data` = row 0.
- Handshake rules:
    - While `m_valid & !m_ready`, `m_data` and `m_last` hold stable.
    - `m_valid` never drops without a handshake.
    - After a handshake on row r < `Dimension-1`, row r+1 appears the next cycle with no bubble.
    - `m_valid` never depends combinationally on `m_ready`.
- After the last handshake:
    - In that cycle's next edge, `m_valid` falls and `done` is 1 for one cycle.
    - `busy` falls in the same cycle as `done` rises.
    - The earliest accepted `start` is in the `done` cycle.
- Best-case tile: 1 (arm) + `Dimension` (capture) + `Dimension` (drain) cycles.
- Reset asserted mid-operation returns all outputs to reset values immediately. The partial tile is discarded.

## Structure
- Shared AXON package holds:
    - the state encoding typedef (IDLE/CAPTURE/DRAIN);
    - the lane-slice helper constant for `DW`;
    - the counter-width function `max(1, $clog2(N))`.
- One sub-module is natural: `axon_row_buffer`.
    - `Dimension` × `DW*Dimension` register file.
    - One write port and one synchronous read port.
    - No reset on storage.
- The FSM, counters and output register live in the top of this block.

## Test plan
- Basic tile, `Dimension=4`, `DW=16`:
    - Stimulus: `start`, then 4 back-to-back beats; row r lane k = 16'h(r*16+k); `m_ready=1`.
    - Response: rows 0..3 on consecutive cycles from one cycle after the last beat; `m_last` on row 3; `done` one cycle later; `err` stays 0.
- Back-pressure:
    - Stimulus: `m_ready` toggles 1,0,0,1,0,1,1.
    - Response: `m_data` is stable across every stall, no row is skipped or repeated, exactly 4 handshakes occur.
- Capture gaps:
    - Stimulus: `capture_valid` pattern 1,0,1,0,0,1,1.
    - Response: the buffer holds exactly the 4 valid rows in order; DRAIN is entered only after the 4th.
- Protocol violations:
    - Stimulus: `capture_valid` in IDLE, and `start` pulsed during DRAIN.
    - Response: `err`=1 and stays 1 until the next accepted `start`; the tile in progress is unaffected.
- Reset mid-drain:
    - Stimulus: assert `rst` low while row 2 is stalled.
    - Response: all outputs 0 in the same cycle; after release, a new `start` with values 16'hA000+k gives a clean tile.
- Degenerate `Dimension=1`:
    - Stimulus: `start`, one beat 16'h7FFF.
    - Response: `m_valid` and `m_last` high the next cycle with `m_data`=16'h7FFF.

Source files
------------

// File: rtl/axon_output_drain_pkg.sv
// Shared AXON definitions: drain FSM encoding, lane geometry and counter sizing.
package axon_output_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } axon_state_t;

  localparam int AXON_DW  = 16;
  localparam int AXON_DIM = 16;

  // Bit offset of lane `lane` inside a packed row of `dw`-bit words.
  function automatic int lane_lsb(input int lane, input int dw);
    return lane * dw;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axon_output_drain_row_buffer.sv
// Tile row store: one write port, one read port whose data is registered by the
// drain output stage in the top. Storage is deliberately not reset.
module axon_row_buffer
  import axon_output_drain_pkg::*;
#(
  parameter int DW        = AXON_DW,
  parameter int Dimension = AXON_DIM,
  localparam int CW       = cnt_width(Dimension)
) (
  input  logic                    clk,
  input  logic                    i_wr_en,
  input  logic [CW-1:0]           i_wr_addr,
  input  logic [DW*Dimension-1:0] i_wr_data,
  input  logic [CW-1:0]           i_rd_addr,
  output logic [DW*Dimension-1:0] o_rd_data
);

  logic [DW*Dimension-1:0] r_mem [Dimension];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/axon_output_drain.sv
// Captures one Dimension-row tile from the PE array, then replays it in capture
// order over a valid/ready stream so the array never sees write-back stalls.
module axon_output_drain
  import axon_output_drain_pkg::*;
#(
  parameter int DW        = AXON_DW,
  parameter int Dimension = AXON_DIM
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    capture_valid,
  input  logic [DW*Dimension-1:0] array_out,
  output logic [DW*Dimension-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int            CW   = cnt_width(Dimension);
  localparam logic [CW-1:0] LAST = CW'(Dimension - 1);

  axon_state_t             r_state, w_state_nxt;
  logic [CW-1:0]           r_wr_cnt, r_rd_cnt, w_rd_addr;
  logic [DW*Dimension-1:0] r_m_data, w_rd_data, w_first_row;
  logic                    r_m_valid, r_m_last, r_done, r_err;
  logic                    w_hs, w_wr_en, w_last_beat, w_last_hs;

  assign w_hs        = r_m_valid & m_ready;
  assign w_wr_en     = (r_state == ST_CAPTURE) & capture_valid;
  assign w_last_beat = w_wr_en & (r_wr_cnt == LAST);
  assign w_last_hs   = (r_state == ST_DRAIN) & w_hs & (r_rd_cnt == LAST);

  // Look one row ahead so the next row is ready the cycle after a handshake.
  assign w_rd_addr = ((r_state == ST_DRAIN) && (r_rd_cnt != LAST)) ? r_rd_cnt + 1'b1 : '0;

  // With a single-row tile, row 0 is still on the bus when it must be presented.
  assign w_first_row = (Dimension == 1) ? array_out : w_rd_data;

  axon_row_buffer #(
    .DW        (DW),
    .Dimension (Dimension)
  ) u_row_buffer (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_cnt),
    .i_wr_data (array_out),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start)       w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (w_last_beat) w_state_nxt = ST_DRAIN;
      ST_DRAIN:   if (w_last_hs)   w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == ST_IDLE) && start) begin
        r_wr_cnt <= '0;
        r_err    <= 1'b0;
      end
      // A stray beat is dropped; its flag wins over a same-cycle clear.
      if (capture_valid && (r_state != ST_CAPTURE)) r_err <= 1'b1;
      if (w_wr_en && !w_last_beat) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_last_beat) begin
        r_m_data  <= w_first_row;
        r_m_valid <= 1'b1;
        r_m_last  <= (Dimension == 1);
        r_rd_cnt  <= '0;
      end
      if ((r_state == ST_DRAIN) && w_hs) begin
        if (w_last_hs) begin
          r_m_valid <= 1'b0;
          r_m_last  <= 1'b0;
          r_done    <= 1'b1;
        end else begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
          r_m_data <= w_rd_data;
          r_m_last <= ((r_rd_cnt + 1'b1) == LAST);
        end
      end
    end
  end

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign done    = r_done;
  assign err     = r_err;
  assign busy    = (r_state != ST_IDLE);

endmodule
